// File: rtl/negedge_delay_pkg.sv
// rtl/negedge_delay_pkg.sv - shared state encodings for the falling-edge delay controller
package negedge_delay_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/negedge_delay_channel.sv
// rtl/negedge_delay_channel.sv - one channel: rise passes after one edge, fall is held off by a countdown
module negedge_delay_channel
    import negedge_delay_pkg::*;
#(
    parameter int CW = 8
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_x,
    input  logic [CW-1:0] i_delay,
    output logic          o_z,
    output logic          o_hold
);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_z;

    // Channel FSM; the delay is sampled only on the HIGH->HOLD step, so a running countdown keeps its count
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_z     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_x) begin
                        r_state <= ST_HIGH;
                        r_z     <= 1'b1;
                    end else begin
                        r_z     <= 1'b0;
                    end
                end
                ST_HIGH: begin
                    if (!i_x) begin
                        if (i_delay == '0) begin
                            r_state <= ST_IDLE;
                            r_z     <= 1'b0;
                        end else begin
                            r_state <= ST_HOLD;
                            r_cnt   <= i_delay - 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_x) begin
                        // Re-rise abandons the countdown; z was never dropped so there is no glitch
                        r_state <= ST_HIGH;
                    end else if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                        r_z     <= 1'b0;
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_z     <= 1'b0;
                end
            endcase
        end
    end

    assign o_z    = r_z;
    assign o_hold = (r_state == ST_HOLD);

endmodule

// File: rtl/negedge_delay_ctrl.sv
// rtl/negedge_delay_ctrl.sv - N-channel falling-edge delay controller with per-channel delay config
module negedge_delay_ctrl
    import negedge_delay_pkg::*;
#(
    parameter int N             = 4,
    parameter int CW            = 8,
    parameter int DEFAULT_DELAY = 5,
    localparam int CHW          = $clog2(N) | 1
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic [N-1:0]   i_x,
    input  logic           i_cfg_valid,
    output logic           o_cfg_ready,
    input  logic [CHW-1:0] i_cfg_ch,
    input  logic [CW-1:0]  i_cfg_delay,
    output logic [N-1:0]   o_z,
    output logic [N-1:0]   o_hold,
    output logic           o_busy
);

    localparam logic [CW-1:0] DEF_D = DEFAULT_DELAY[CW-1:0];
    localparam logic [CHW:0]  N_CH  = N[CHW:0];

    logic [N-1:0][CW-1:0] r_delay;
    logic                 r_cfg_ready;
    logic                 w_cfg_wr;
    logic [N-1:0]         w_hold;

    // Writes to channel numbers at or beyond N are dropped
    assign w_cfg_wr = i_cfg_valid & r_cfg_ready & ({1'b0, i_cfg_ch} < N_CH);

    // Config port stays closed for the first clock after reset release
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cfg_ready <= 1'b0;
        end else begin
            r_cfg_ready <= 1'b1;
        end
    end

    // Delay register file; channels read the pre-write value on the write edge
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < N; i++) begin
                r_delay[i] <= DEF_D;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (w_cfg_wr && (i_cfg_ch == CHW'(i))) begin
                    r_delay[i] <= i_cfg_delay;
                end
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_ch
        negedge_delay_channel #(
            .CW(CW)
        ) u_ch (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_x     (i_x[g]),
            .i_delay (r_delay[g]),
            .o_z     (o_z[g]),
            .o_hold  (w_hold[g])
        );
    end

    assign o_cfg_ready = r_cfg_ready;
    assign o_hold      = w_hold;
    assign o_busy      = |w_hold;

endmodule

// File: tb/tb_negedge_delay_ctrl.sv
// tb/tb_negedge_delay_ctrl.sv - directed self-checking bench for negedge_delay_ctrl
module tb_negedge_delay_ctrl;

    logic       clk;
    logic       rst;
    logic [3:0] x;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_ch;
    logic [7:0] cfg_delay;
    logic [3:0] z;
    logic [3:0] hold;
    logic       busy;

    int errors;
    int checks;

    negedge_delay_ctrl #(
        .N(4),
        .CW(8),
        .DEFAULT_DELAY(5)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_x         (x),
        .i_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .i_cfg_ch    (cfg_ch),
        .i_cfg_delay (cfg_delay),
        .o_z         (z),
        .o_hold      (hold),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [7:0] d);
        cfg_ch    = ch;
        cfg_delay = d;
        cfg_valid = 1'b1;
        tick(1);
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; x = '0; cfg_valid = 1'b0; cfg_ch = '0; cfg_delay = '0;
        tick(2);
        checks++; if (z !== 4'h0) begin errors++; $display("FAIL reset_z: got %h want 0", z); end
        checks++; if (hold !== 4'h0) begin errors++; $display("FAIL reset_hold: got %h want 0", hold); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", cfg_ready); end
        rst = 1'b0;
        #1;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ready_first_cycle: got %b want 0", cfg_ready); end
        tick(1);
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_after: got %b want 1", cfg_ready); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dut.r_delay[i] !== 8'd5) begin errors++; $display("FAIL reset_delay%0d: got %0d want 5", i, dut.r_delay[i]); end
        end
    endtask

    task automatic test_rise_hold;
        x[0] = 1'b1;
        tick(1);
        checks++; if (z[0] !== 1'b1 || hold[0] !== 1'b0) begin errors++; $display("FAIL ch0_rise: got z=%b hold=%b want z=1 hold=0", z[0], hold[0]); end
        tick(9);
        x[0] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            checks++; if (z[0] !== 1'b1 || hold[0] !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL ch0_hold%0d: got z=%b hold=%b busy=%b want 1 1 1", k, z[0], hold[0], busy); end
        end
        tick(1);
        checks++; if (z[0] !== 1'b0 || hold[0] !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ch0_fall: got z=%b hold=%b busy=%b want 0 0 0", z[0], hold[0], busy); end
    endtask

    task automatic test_zero_delay;
        cfg_write(3'd1, 8'd0);
        checks++; if (dut.r_delay[1] !== 8'd0) begin errors++; $display("FAIL ch1_write: got %0d want 0", dut.r_delay[1]); end
        x[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            checks++; if (z[1] !== 1'b1 || hold[1] !== 1'b0) begin errors++; $display("FAIL ch1_high%0d: got z=%b hold=%b want 1 0", k, z[1], hold[1]); end
        end
        x[1] = 1'b0;
        tick(1);
        checks++; if (z[1] !== 1'b0 || hold[1] !== 1'b0) begin errors++; $display("FAIL ch1_d0_fall: got z=%b hold=%b want 0 0", z[1], hold[1]); end
    endtask

    task automatic test_same_edge;
        x[1] = 1'b1;
        tick(1);
        x[1] = 1'b0;
        cfg_write(3'd1, 8'd3);
        checks++; if (z[1] !== 1'b0 || hold[1] !== 1'b0) begin errors++; $display("FAIL same_edge_old_d: got z=%b hold=%b want 0 0", z[1], hold[1]); end
        checks++; if (dut.r_delay[1] !== 8'd3) begin errors++; $display("FAIL same_edge_write: got %0d want 3", dut.r_delay[1]); end
        x[1] = 1'b1;
        tick(1);
        x[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            checks++; if (z[1] !== 1'b1 || hold[1] !== 1'b1) begin errors++; $display("FAIL ch1_d3_hold%0d: got z=%b hold=%b want 1 1", k, z[1], hold[1]); end
        end
        tick(1);
        checks++; if (z[1] !== 1'b0) begin errors++; $display("FAIL ch1_d3_fall: got z=%b want 0", z[1]); end
    endtask

    task automatic test_retrigger;
        x[2] = 1'b1;
        tick(2);
        x[2] = 1'b0;
        tick(2);
        checks++; if (hold[2] !== 1'b1) begin errors++; $display("FAIL ch2_counting: got hold=%b want 1", hold[2]); end
        x[2] = 1'b1;
        tick(1);
        checks++; if (z[2] !== 1'b1 || hold[2] !== 1'b0 || dut.g_ch[2].u_ch.r_state !== negedge_delay_pkg::ST_HIGH) begin
            errors++; $display("FAIL ch2_retrig: got z=%b hold=%b want 1 0 in HIGH", z[2], hold[2]);
        end
        tick(7);
        checks++; if (z[2] !== 1'b1) begin errors++; $display("FAIL ch2_stay: got z=%b want 1", z[2]); end
        x[2] = 1'b0;
        tick(5);
        checks++; if (z[2] !== 1'b1 || hold[2] !== 1'b1) begin errors++; $display("FAIL ch2_pre_fall: got z=%b hold=%b want 1 1", z[2], hold[2]); end
        tick(1);
        checks++; if (z[2] !== 1'b0 || hold[2] !== 1'b0) begin errors++; $display("FAIL ch2_fall: got z=%b hold=%b want 0 0", z[2], hold[2]); end
    endtask

    task automatic test_cfg_during_hold;
        x[3] = 1'b1;
        tick(1);
        x[3] = 1'b0;
        tick(1);
        cfg_write(3'd3, 8'd2);
        tick(3);
        checks++; if (z[3] !== 1'b1 || hold[3] !== 1'b1) begin errors++; $display("FAIL ch3_keeps_count: got z=%b hold=%b want 1 1", z[3], hold[3]); end
        tick(1);
        checks++; if (z[3] !== 1'b0) begin errors++; $display("FAIL ch3_fall_old: got z=%b want 0", z[3]); end
        x[3] = 1'b1;
        tick(1);
        x[3] = 1'b0;
        tick(2);
        checks++; if (z[3] !== 1'b1 || hold[3] !== 1'b1) begin errors++; $display("FAIL ch3_new_hold: got z=%b hold=%b want 1 1", z[3], hold[3]); end
        tick(1);
        checks++; if (z[3] !== 1'b0 || hold[3] !== 1'b0) begin errors++; $display("FAIL ch3_fall_new: got z=%b hold=%b want 0 0", z[3], hold[3]); end
    endtask

    task automatic test_max_delay;
        int n;
        cfg_write(3'd2, 8'd255);
        x[2] = 1'b1;
        tick(1);
        x[2] = 1'b0;
        tick(1);
        n = 0;
        while (z[2] === 1'b1 && n < 300) begin
            tick(1);
            n++;
        end
        checks++; if (n !== 255) begin errors++; $display("FAIL max_delay_len: got %0d edges want 255", n); end
        checks++; if (z !== 4'h0 || hold !== 4'h0) begin errors++; $display("FAIL max_delay_end: got z=%h hold=%h want 0 0", z, hold); end
    endtask

    task automatic test_reset_mid_hold;
        x[0] = 1'b1;
        tick(1);
        x[0] = 1'b0;
        tick(2);
        checks++; if (hold[0] !== 1'b1) begin errors++; $display("FAIL ch0_pre_reset: got hold=%b want 1", hold[0]); end
        #2 rst = 1'b1;
        #1;
        checks++; if (z[0] !== 1'b0 || hold[0] !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b0) begin
            errors++; $display("FAIL async_reset: got z=%b hold=%b busy=%b ready=%b want 0 0 0 0", z[0], hold[0], busy, cfg_ready);
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (dut.r_delay[i] !== 8'd5) begin errors++; $display("FAIL reset_restore%0d: got %0d want 5", i, dut.r_delay[i]); end
        end
        tick(1);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_bad_ch;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL bad_ch_ready: got %b want 1", cfg_ready); end
        cfg_write(3'd7, 8'd9);
        cfg_write(3'd4, 8'd9);
        for (int i = 0; i < 4; i++) begin
            checks++; if (dut.r_delay[i] !== 8'd5) begin errors++; $display("FAIL bad_ch_delay%0d: got %0d want 5", i, dut.r_delay[i]); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset;
        test_rise_hold;
        test_zero_delay;
        test_same_edge;
        test_retrigger;
        test_cfg_during_hold;
        test_max_delay;
        test_reset_mid_hold;
        test_bad_ch;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
